// File: rtl/RouterPkg.sv
// Shared router types: packet format, output-queue state encoding, port/queue sizing.
// Latency: n/a (types only). Backpressure: n/a.
package RouterPkg;

    localparam int PORT_COUNT  = 4;
    localparam int QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [1:0]  dest;
        logic [7:0]  seq;
        logic [31:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } q_state_e;

    function automatic logic is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// Packet storage ring with read/write pointers; write on clock edge, read is combinational.
// Latency: written entry readable the cycle after the write. Backpressure: none, caller gates enables.
module pkt_fifo_mem
    import RouterPkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_wr_en,
    input  pkt_t i_wr_pkt,
    input  logic i_rd_en,
    output pkt_t o_rd_pkt
);

    localparam int AW = $clog2(DEPTH);

    pkt_t           r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;

    // DEPTH is a power of two, so the natural pointer overflow is the wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_pkt;
    end

    assign o_rd_pkt = r_mem[r_rd_ptr];

endmodule

// File: rtl/out_port_queue.sv
// Per-output-lane packet queue (first-word fall-through) with overflow drop counter.
// Latency: push to out_valid one cycle. Backpressure: in_ready low when full; offers while full are dropped and counted.
module out_port_queue
    import RouterPkg::*;
#(
    parameter int DEPTH   = QUEUE_DEPTH,
    parameter int PORT_ID = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  pkt_t                   in_pkt,
    input  logic                   in_valid,
    output logic                   in_ready,
    output pkt_t                   out_pkt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             drop_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (!is_pow2(DEPTH) || (PORT_ID < 0) || (PORT_ID >= PORT_COUNT)) begin : g_param_check
        $error("out_port_queue: DEPTH must be a power of two >= 2 and PORT_ID in 0..3");
    end

    q_state_e       r_state;
    q_state_e       w_state_nxt;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_nxt;
    logic [7:0]     r_drop_count;
    logic           w_push;
    logic           w_pop;
    logic           w_drop;
    pkt_t           w_head;

    // Handshakes decode from the registered state only, so out_ready never reaches in_ready.
    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;
    assign w_drop = in_valid && !in_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_push) w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (w_count_nxt == CW'(DEPTH)) w_state_nxt = FULL;
                else if (w_count_nxt == '0)    w_state_nxt = EMPTY;
            end
            FULL: begin
                if (w_pop) w_state_nxt = ACTIVE;
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    pkt_fifo_mem #(
        .DEPTH    (DEPTH)
    ) u_mem (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_wr_en  (w_push),
        .i_wr_pkt (in_pkt),
        .i_rd_en  (w_pop),
        .o_rd_pkt (w_head)
    );

    assign out_pkt    = out_valid ? w_head : '0;
    assign count      = r_count;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_out_port_queue.sv
// Bench for out_port_queue: queue-based reference model checked every cycle, plus pinned literal scenarios.
module tb_out_port_queue;
    import RouterPkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clock = 1'b0;
    logic           reset_n;
    pkt_t           in_pkt;
    logic           in_valid;
    logic           in_ready;
    pkt_t           out_pkt;
    logic           out_valid;
    logic           out_ready;
    logic [CW-1:0]  count;
    logic [7:0]     drop_count;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    out_port_queue #(
        .DEPTH      (DEPTH),
        .PORT_ID    (0)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_pkt     (in_pkt),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_pkt    (out_pkt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .drop_count (drop_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of stored packets and a saturating drop tally.
    pkt_t mq[$];
    int   m_drops = 0;
    bit   m_full;
    bit   m_pop;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_drops = 0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() != 0) && out_ready;
            if (in_valid && m_full && m_drops < 255) m_drops++;
            if (m_pop) void'(mq.pop_front());
            if (in_valid && !m_full) mq.push_back(in_pkt);
        end
    end

    pkt_t m_head;
    always @(negedge clock) begin
        if (cmp_en) begin
            m_head = '0;
            if (mq.size() != 0) m_head = mq[0];
            chk("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("m_in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
            chk("m_count", 64'(count), 64'(mq.size()));
            chk("m_drop_count", 64'(drop_count), 64'(m_drops));
            chk("m_out_pkt", 64'(out_pkt), 64'(m_head));
        end
    end

    function automatic pkt_t mk(input int n);
        pkt_t p;
        p.dest = 2'd0;
        p.seq  = 8'(n);
        p.data = 32'hC0DE0000 + 32'(n);
        return p;
    endfunction

    task automatic step(input logic v, input pkt_t p, input logic r);
        in_valid  = v;
        in_pkt    = p;
        out_ready = r;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        @(posedge clock);
        #3;
        reset_n = 1'b1;
    endtask

    pkt_t rp;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_pkt    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        cmp_en = 1'b1;

        @(negedge clock);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pkt", 64'(out_pkt), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);

        // First edge after release accepts the push; head visible one cycle later.
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        step(1'b1, mk(1), 1'b0);
        chk("first_out_valid", 64'(out_valid), 64'd1);
        chk("first_out_pkt", 64'(out_pkt), 64'(mk(1)));
        chk("first_count", 64'(count), 64'd1);
        step(1'b0, '0, 1'b1);
        chk("pop_to_empty_count", 64'(count), 64'd0);
        chk("empty_out_pkt_zero", 64'(out_pkt), 64'd0);
        step(1'b0, '0, 1'b1);
        chk("pop_on_empty_count", 64'(count), 64'd0);

        for (int i = 1; i <= 5; i++) step(1'b1, mk(100 + i), 1'b0);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_drop", 64'(drop_count), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("fill_order", 64'(out_pkt), 64'(mk(100 + i)));
            step(1'b0, '0, 1'b1);
        end
        chk("drained_count", 64'(count), 64'd0);

        for (int i = 1; i <= 4; i++) step(1'b1, mk(10 + i), 1'b0);
        step(1'b1, mk(99), 1'b1);
        chk("full_pushpop_count", 64'(count), 64'd3);
        chk("full_pushpop_drop", 64'(drop_count), 64'd2);
        chk("full_pushpop_head", 64'(out_pkt), 64'(mk(12)));

        step(1'b0, '0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, mk(20 + k), 1'b1);
            chk("steady_count", 64'(count), 64'd2);
        end
        chk("steady_head", 64'(out_pkt), 64'(mk(28)));

        // Reset between edges clears the queue without a clock.
        step(1'b1, mk(40), 1'b0);
        chk("pre_reset_count", 64'(count), 64'd3);
        in_valid = 1'b0;
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_pkt", 64'(out_pkt), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        step(1'b1, mk(41), 1'b0);
        chk("post_rst_out_valid", 64'(out_valid), 64'd1);
        chk("post_rst_out_pkt", 64'(out_pkt), 64'(mk(41)));
        chk("post_rst_count", 64'(count), 64'd1);

        repeat (3000) begin
            rp.dest = 2'($urandom_range(0, 3));
            rp.seq  = 8'($urandom);
            rp.data = $urandom;
            step($urandom_range(0, 99) < 60, rp, $urandom_range(0, 99) < 45);
        end
        repeat (DEPTH + 1) step(1'b0, '0, 1'b1);
        chk("random_drain_count", 64'(count), 64'd0);

        pulse_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, mk(200 + i), 1'b0);
        for (int i = 0; i < 254; i++) step(1'b1, mk(i), 1'b0);
        chk("sat_pre_drop", 64'(drop_count), 64'd254);
        for (int i = 0; i < 46; i++) step(1'b1, mk(i), 1'b0);
        chk("sat_drop", 64'(drop_count), 64'd255);
        chk("sat_count", 64'(count), 64'd4);
        chk("sat_head", 64'(out_pkt), 64'(mk(200)));

        in_valid = 1'b0;
        @(negedge clock);
        #1;
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/out_port_queue.md
OUT_PORT_QUEUE -- requirements
Module: out_port_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue capacity in packets; SHALL be a power of two, at least 2.
REQ-002 Parameter PORT_ID, default 0, index of the routing-logic output lane this queue serves (0..3).
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_pkt  input  pkt_t  packet from the routing-logic output lane PORT_ID.
REQ-006 in_valid  input  1  in_pkt carries a real packet this cycle.
REQ-007 in_ready  output  1  queue can accept a packet this cycle.
REQ-008 out_pkt  output  pkt_t  head-of-queue packet toward the link.
REQ-009 out_valid  output  1  out_pkt is valid.
REQ-010 out_ready  input  1  link consumes out_pkt this cycle.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 drop_count  output  8  number of packets dropped because the queue was full.

Function
REQ-013 Push occurs when in_valid && in_ready is high at a clock edge; pop occurs when out_valid && out_ready is high at a clock edge.
REQ-014 in_ready SHALL equal (count != DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-015 out_valid SHALL equal (count != 0); out_pkt SHALL present the oldest stored packet (first-word fall-through).
REQ-016 A packet pushed into an empty queue SHALL appear on out_pkt with out_valid high one cycle after the push edge.
REQ-017 Packets SHALL leave in strict arrival order, bit-exact.
REQ-018 Push and pop in the same cycle with 0 < count < DEPTH SHALL leave count unchanged and both operations SHALL take effect.
REQ-019 When count == DEPTH, a pop SHALL still occur; a simultaneous in_valid SHALL NOT be stored, because in_ready is low.
REQ-020 When count == 0, out_ready SHALL have no effect.
REQ-021 A packet offered with in_valid high while in_ready is low SHALL be dropped and SHALL increment drop_count by 1.
REQ-022 drop_count SHALL saturate at 255.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without stalling.
REQ-024 When out_valid is low, out_pkt SHALL be driven to '0.
REQ-025 State machine with states EMPTY, ACTIVE and FULL:
- EMPTY -> ACTIVE on push.
- ACTIVE -> FULL when count reaches DEPTH.
- ACTIVE -> EMPTY when count reaches 0.
- FULL -> ACTIVE on pop.
- count, in_ready and out_valid SHALL be consistent with the current state.

Reset
REQ-026 While reset_n is low, the block SHALL hold:
- count = 0, state = EMPTY, both pointers = 0
- drop_count = 0
- out_valid = 0, out_pkt = '0
- in_ready = 1
REQ-027 Reset asserted mid-operation SHALL discard all queued packets immediately, without waiting for a clock edge.
REQ-028 The first push SHALL be accepted on the first rising edge after reset_n deasserts.
REQ-029 Storage array contents need not be reset.

Structure
REQ-030 pkt_t, the queue state enum, PORT_COUNT (4) and QUEUE_DEPTH default SHALL reside in RouterPkg; Router.svh SHALL supply the shared macros.
REQ-031 Packet storage with its pointers SHALL be one sub-module, pkt_fifo_mem, which is write-synchronous with asynchronous read.
REQ-032 out_port_queue SHALL contain the state machine, occupancy and drop counters, and handshake logic.
REQ-033 The router top SHALL instantiate four queues, PORT_ID 0..3, each fed by the matching lane of the routing logic.

Verification
REQ-034 Reset, then push A with dest=0 on cycle 1 -> out_valid=1 and out_pkt=A on cycle 2; count=1.
REQ-035 DEPTH=4, out_ready=0, push 5 packets P1..P5 -> count=4, in_ready=0, drop_count=1; pops then return P1..P4 in order.
REQ-036 Queue at count=2, push and pop together for 10 cycles -> count remains 2 throughout and output order is preserved across pointer wrap.
REQ-037 Full queue, in_valid=1 and out_ready=1 together -> one pop, no store, count=3, drop_count incremented by 1.
REQ-038 Assert reset_n low between clock edges with count=3 -> count=0 and out_valid=0 immediately; first push after release appears one cycle later.
REQ-039 Hold a full queue and offer 300 packets -> drop_count saturates at 255 and does not wrap to 0.
